// File: rtl/gfx256_pkg.sv
// rtl/gfx256_pkg.sv - shared types and constants for the gfx256 memory-port logic
package gfx256_pkg;

    localparam int GFX_RD_TIMEOUT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ACK,
        ST_HOLDOFF
    } rd_state_e;

endpackage

// File: rtl/gfx256_rr_pick.sv
// rtl/gfx256_rr_pick.sv - round-robin picker: first set request at or after the pointer, wrapping
module gfx256_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is the last one written.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            cand = {1'b0, ptr_i} + (IDX_W + 1)'(off);
            if (cand >= (IDX_W + 1)'(NREQ)) begin
                cand = cand - (IDX_W + 1)'(NREQ);
            end
            if (req_i[cand[IDX_W-1:0]]) begin
                vld_o = 1'b1;
                idx_o = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/gfx256_rdport_arbiter.sv
// rtl/gfx256_rdport_arbiter.sv - round-robin arbiter sharing the 256-bit graphics-memory read port
module gfx256_rdport_arbiter
    import gfx256_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*32-1:0] adr_i,
    input  logic [NREQ*32-1:0] sel_i,
    output logic [NREQ-1:0]    ack_o,
    output logic [NREQ-1:0]    err_o,
    output logic [255:0]       dat_o,
    output logic               m_cyc_o,
    output logic               m_stb_o,
    output logic               m_we_o,
    output logic [31:0]        m_sel_o,
    output logic [31:0]        m_adr_o,
    input  logic               m_ack_i,
    input  logic [255:0]       m_dat_i,
    output logic               busy_o
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [GFX_RD_TIMEOUT_W-1:0] CNT_LAST = GFX_RD_TIMEOUT_W'(TIMEOUT - 1);

    rd_state_e                   state_q, state_d;
    logic [IDX_W-1:0]            gnt_q, gnt_d;
    logic [IDX_W-1:0]            rr_q, rr_d;
    logic [NREQ-1:0]             hold_q, hold_d;
    logic [NREQ-1:0]             ack_q, ack_d;
    logic [NREQ-1:0]             err_q, err_d;
    logic [GFX_RD_TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [31:0]                 adr_q, adr_d;
    logic [31:0]                 sel_q, sel_d;
    logic [255:0]                dat_q, dat_d;
    logic                        cyc_q, cyc_d;

    logic [NREQ-1:0]  eligible;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [31:0]      adr_arr [NREQ];
    logic [31:0]      sel_arr [NREQ];

    for (genvar n = 0; n < NREQ; n++) begin : g_unpack
        assign adr_arr[n] = adr_i[32*n +: 32];
        assign sel_arr[n] = sel_i[32*n +: 32];
    end

    assign eligible = req_i & ~hold_q;

    gfx256_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (eligible),
        .ptr_i (rr_q),
        .vld_o (pick_vld),
        .idx_o (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        ack_d   = '0;
        err_d   = '0;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        cyc_d   = cyc_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick_idx;
                    adr_d   = adr_arr[pick_idx] & ~32'h0000_001F;
                    sel_d   = sel_arr[pick_idx];
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (m_ack_i) begin
                    dat_d        = m_dat_i;
                    cyc_d        = 1'b0;
                    ack_d[gnt_q] = 1'b1;
                    state_d      = ST_ACK;
                end else if (cnt_q == CNT_LAST) begin
                    // A stalled bridge must not wedge every drawing engine; abort with an error ack.
                    dat_d        = '0;
                    cyc_d        = 1'b0;
                    ack_d[gnt_q] = 1'b1;
                    err_d[gnt_q] = 1'b1;
                    state_d      = ST_ACK;
                end
            end
            ST_ACK: begin
                rr_d          = (gnt_q == IDX_W'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                hold_d        = '0;
                hold_d[gnt_q] = 1'b1;
                state_d       = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                hold_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            cyc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            cyc_q   <= cyc_d;
        end
    end

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign dat_o   = dat_q;
    assign m_cyc_o = cyc_q;
    assign m_stb_o = cyc_q;
    assign m_we_o  = 1'b0;
    assign m_sel_o = sel_q;
    assign m_adr_o = adr_q;
    assign busy_o  = (state_q != ST_IDLE);

endmodule
